// File: rtl/sram_dp.sv
// Simple dual-port synchronous RAM: byte-enabled write port, read port with
// optional output register, selectable collision policy and a zero-fill sequencer.
module sram_dp #(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned BYTE_WIDTH  = 8,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned OUT_REG     = 0,
   parameter int unsigned WRITE_FIRST = 0
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst_n,
   input  logic                                 i_wr_en,
   input  logic [ADDR_WIDTH-1:0]                i_wr_addr,
   input  logic [DATA_WIDTH-1:0]                i_wr_data,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     i_wr_be,
   input  logic                                 i_rd_en,
   input  logic [ADDR_WIDTH-1:0]                i_rd_addr,
   output logic [DATA_WIDTH-1:0]                o_rd_data,
   output logic                                 o_rd_valid,
   input  logic                                 i_clear,
   output logic                                 o_busy
);

   localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH;

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   clr_cnt;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    wr_acc_c;
   logic                    rd_acc_c;
   logic                    rd_in_c;
   logic                    coll_c;
   logic [DATA_WIDTH-1:0]   old_c;
   logic [DATA_WIDTH-1:0]   merged_c;
   logic [DATA_WIDTH-1:0]   rd_word_c;

   logic                    s1_valid;
   logic [DATA_WIDTH-1:0]   s1_data;

   assign wr_acc_c  = i_wr_en && !o_busy && (32'(i_wr_addr) < DEPTH);
   assign rd_in_c   = 32'(i_rd_addr) < DEPTH;
   assign rd_acc_c  = i_rd_en && !o_busy;
   assign coll_c    = wr_acc_c && rd_acc_c && (i_wr_addr == i_rd_addr);
   assign old_c     = rd_in_c ? mem[i_rd_addr] : '0;
   assign rd_word_c = ((WRITE_FIRST != 0) && coll_c) ? merged_c : old_c;

   // Word a write-first read returns on a collision: new enabled bytes over the old word.
   always_comb begin
      merged_c = old_c;
      for (int unsigned b = 0; b < NB; b++) begin
         if (i_wr_be[b]) begin
            merged_c[b*BYTE_WIDTH +: BYTE_WIDTH] = i_wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   // Storage array is never reset; the sweep owns the write port while clearing.
   always_ff @(posedge i_clk) begin
      if (state == ST_CLEAR) begin
         mem[clr_cnt] <= '0;
      end else if (wr_acc_c) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (i_wr_be[b]) begin
               mem[i_wr_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= i_wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   // Clear sequencer: one zero word per cycle from address 0 up to DEPTH-1.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= ST_IDLE;
         clr_cnt <= '0;
         o_busy  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_clear) begin
                  state   <= ST_CLEAR;
                  clr_cnt <= '0;
                  o_busy  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                  state  <= ST_IDLE;
                  o_busy <= 1'b0;
               end else begin
                  clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
               end
            end
            default: begin
               state  <= ST_IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= rd_acc_c;
         if (rd_acc_c) begin
            s1_data <= rd_word_c;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               o_rd_valid <= 1'b0;
               o_rd_data  <= '0;
            end else begin
               o_rd_valid <= s1_valid;
               if (s1_valid) begin
                  o_rd_data <= s1_data;
               end
            end
         end
      end else begin : g_no_out_reg
         assign o_rd_valid = s1_valid;
         assign o_rd_data  = s1_data;
      end
   endgenerate

endmodule

// File: tb/tb_sram_dp.sv
// Directed bench for sram_dp: two instances driven in lockstep, one with the
// default configuration and one with DEPTH=200, OUT_REG=1, WRITE_FIRST=1.
module tb_sram_dp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic        clear;

   logic [31:0] rd_data0, rd_data1;
   logic        rd_valid0, rd_valid1;
   logic        busy0, busy1;

   logic [31:0] m0 [256];
   logic [31:0] m1 [256];

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   sram_dp u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_be(wr_be),
      .i_rd_en(rd_en), .i_rd_addr(rd_addr),
      .o_rd_data(rd_data0), .o_rd_valid(rd_valid0),
      .i_clear(clear), .o_busy(busy0)
   );

   sram_dp #(.DEPTH(200), .OUT_REG(1), .WRITE_FIRST(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_be(wr_be),
      .i_rd_en(rd_en), .i_rd_addr(rd_addr),
      .o_rd_data(rd_data1), .o_rd_valid(rd_valid1),
      .i_clear(clear), .o_busy(busy1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_write(input int unsigned a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 8'(a); wr_data = d; wr_be = be;
      @(posedge clk); #1;
      wr_en = 1'b0;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) begin
            m0[a][b*8 +: 8] = d[b*8 +: 8];
            if (a < 200) m1[a][b*8 +: 8] = d[b*8 +: 8];
         end
      end
   endtask

   // dut0 answers one cycle after the read, dut1 two cycles after.
   task automatic do_read(input int unsigned a);
      @(negedge clk);
      rd_en = 1'b1; rd_addr = 8'(a);
      @(posedge clk); #1;
      rd_en = 1'b0;
      chk($sformatf("rd%0d_v0_l1", a), 32'(rd_valid0), 32'd1);
      chk($sformatf("rd%0d_d0", a), rd_data0, m0[a]);
      chk($sformatf("rd%0d_v1_l1", a), 32'(rd_valid1), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("rd%0d_v0_l2", a), 32'(rd_valid0), 32'd0);
      chk($sformatf("rd%0d_v1_l2", a), 32'(rd_valid1), 32'd1);
      chk($sformatf("rd%0d_d1", a), rd_data1, m1[a]);
   endtask

   task automatic stream(input string tag);
      for (int i = 0; i <= 256; i++) begin
         @(negedge clk);
         rd_en = (i < 256); rd_addr = 8'(i);
         @(posedge clk); #1;
         if (i < 256) begin
            chk($sformatf("%s_v0[%0d]", tag, i), 32'(rd_valid0), 32'd1);
            chk($sformatf("%s_d0[%0d]", tag, i), rd_data0, m0[i]);
         end else begin
            chk($sformatf("%s_v0_end", tag), 32'(rd_valid0), 32'd0);
         end
         if (i > 0) begin
            chk($sformatf("%s_v1[%0d]", tag, i-1), 32'(rd_valid1), 32'd1);
            chk($sformatf("%s_d1[%0d]", tag, i-1), rd_data1, m1[i-1]);
         end else begin
            chk($sformatf("%s_v1_first", tag), 32'(rd_valid1), 32'd0);
         end
      end
      rd_en = 1'b0;
   endtask

   task automatic fill(input int unsigned k, input int unsigned c);
      for (int unsigned a = 0; a < 256; a++) do_write(a, a * k + c, 4'hF);
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   initial begin
      int unsigned c0, c1;
      logic done;
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
      rd_en = 1'b0; rd_addr = '0; clear = 1'b0;
      for (int i = 0; i < 256; i++) begin m0[i] = '0; m1[i] = '0; end

      repeat (3) @(posedge clk);
      #1;
      chk("rst_d0", rd_data0, 32'd0);   chk("rst_v0", 32'(rd_valid0), 32'd0);
      chk("rst_b0", 32'(busy0), 32'd0); chk("rst_d1", rd_data1, 32'd0);
      chk("rst_v1", 32'(rd_valid1), 32'd0); chk("rst_b1", 32'(busy1), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // Byte enables: expect AA22CC44 from both instances.
      do_write(5, 32'hAABBCCDD, 4'hF);
      do_write(5, 32'h11223344, 4'b0101);
      chk("be_model", m0[5], 32'hAA22CC44);
      do_read(5);

      // Same-address collision: old word on dut0, merged word on dut1.
      do_write(3, 32'h0, 4'hF);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 8'd3; wr_data = 32'hFFFFFFFF; wr_be = 4'b0011;
      rd_en = 1'b1; rd_addr = 8'd3;
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0;
      chk("coll_v0", 32'(rd_valid0), 32'd1);
      chk("coll_d0", rd_data0, 32'h00000000);
      @(posedge clk); #1;
      chk("coll_v1", 32'(rd_valid1), 32'd1);
      chk("coll_d1", rd_data1, 32'h0000FFFF);
      m0[3] = 32'h0000FFFF; m1[3] = 32'h0000FFFF;
      do_read(3);

      fill(3, 0);
      stream("str");

      // Out-of-range on dut1 (DEPTH=200), in range on dut0.
      do_write(220, 32'hDEADBEEF, 4'hF);
      do_read(220);
      stream("oor");

      // Clear: attempted write/read mid-sweep must be ignored.
      fill(3, 1);
      pulse_clear();
      chk("clr_b0_rise", 32'(busy0), 32'd1);
      chk("clr_b1_rise", 32'(busy1), 32'd1);
      c0 = 0; c1 = 0;
      for (int n = 0; n < 300; n++) begin
         if (busy0) c0++;
         if (busy1) c1++;
         @(negedge clk);
         wr_en = (n == 50); wr_addr = 8'd10; wr_data = 32'h12345678; wr_be = 4'hF;
         rd_en = (n == 50); rd_addr = 8'd10;
         @(posedge clk); #1;
         wr_en = 1'b0; rd_en = 1'b0;
         if (n == 50 || n == 51) begin
            chk($sformatf("busy_rd_v0_%0d", n), 32'(rd_valid0), 32'd0);
            chk($sformatf("busy_rd_v1_%0d", n), 32'(rd_valid1), 32'd0);
         end
      end
      chk("clr_len0", c0, 32'd256);
      chk("clr_len1", c1, 32'd200);
      for (int i = 0; i < 256; i++) begin m0[i] = '0; m1[i] = '0; end
      stream("clr");

      // Reset during sweep: addresses 0..99 zeroed, the rest untouched.
      fill(5, 7);
      stream("pre");
      pulse_clear();
      repeat (100) @(posedge clk);
      #1; rst_n = 1'b0; #1;
      chk("mrst_d0", rd_data0, 32'd0);   chk("mrst_v0", 32'(rd_valid0), 32'd0);
      chk("mrst_b0", 32'(busy0), 32'd0); chk("mrst_d1", rd_data1, 32'd0);
      chk("mrst_v1", 32'(rd_valid1), 32'd0); chk("mrst_b1", 32'(busy1), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin m0[i] = '0; m1[i] = '0; end
      stream("mrst");

      pulse_clear();
      chk("reclr_b0", 32'(busy0), 32'd1);
      chk("reclr_b1", 32'(busy1), 32'd1);
      done = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(posedge clk); #1;
         done = !busy0 && !busy1;
      end
      chk("reclr_done", 32'(done), 32'd1);
      for (int i = 0; i < 256; i++) begin m0[i] = '0; m1[i] = '0; end
      do_read(150);
      do_read(255);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
